// File: rtl/maxpool_stream.sv
// -----------------------------------------------------------------------------
// maxpool_stream
//
// 2x2, stride-2 max pooling of a signed int8 feature map carried on
// AXI-Stream. Each 32-bit input word holds four pixels, with byte 0 at the
// lowest x. Each 32-bit output word holds four pooled pixels in the same
// byte order.
//
// Data path per accepted word:
//   - A horizontal max is taken first: h0 = max(p0,p1) and h1 = max(p2,p3).
//   - On even rows, the pair {h1,h0} is parked in a line buffer at the
//     current column.
//   - On odd rows, the parked pair is read back in the same cycle and a
//     vertical max is taken against it.
//   - Two consecutive odd-row words form one output word. Bytes 0 and 1 come
//     from the earlier word.
//
// Ports:
//   clk, rst        single clock domain; rst is synchronous, active high
//   start           one-cycle pulse; latches width_ex/height_ex, begins frame
//   width_ex        row width in pixels; bits [2:0] are ignored
//   height_ex       frame height in rows
//   pool_done       one-cycle pulse when a frame completes
//   tlast_err       sticky; upstream TLAST disagreed with the frame geometry
//   S_AXIS_*        input stream (TDATA/TLAST/TVALID in, TREADY out)
//   M_AXIS_*        output stream (TDATA/TKEEP/TLAST/TVALID out, TREADY in)
// -----------------------------------------------------------------------------
module maxpool_stream #(
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int LB_DEPTH               = 64
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [8:0]                        width_ex,
    input  logic [8:0]                        height_ex,
    output logic                              pool_done,
    output logic                              tlast_err,
    output logic                              S_AXIS_TREADY,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic                              S_AXIS_TLAST,
    input  logic                              S_AXIS_TVALID,
    input  logic                              M_AXIS_TREADY,
    output logic [C_S00_AXIS_TDATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic [3:0]                        M_AXIS_TKEEP,
    output logic                              M_AXIS_TLAST,
    output logic                              M_AXIS_TVALID
);

    localparam int         LB_AW = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
    localparam logic [8:0] MAX_W = 9'(4 * LB_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    // Signed 8-bit maximum. The bytes are carried as plain vectors, so the
    // comparison is cast explicitly.
    function automatic logic [7:0] smax8(input logic [7:0] a, input logic [7:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    // -------------------------------------------------------------------------
    // State and registers
    // -------------------------------------------------------------------------
    state_t            state_q;
    state_t            state_d;

    logic [LB_AW-1:0]  col_q;        // input word index within the row
    logic [LB_AW-1:0]  col_last_q;   // WR-1 for the latched geometry
    logic [8:0]        row_q;        // input row index
    logic [8:0]        height_q;     // latched frame height
    logic              half_q;       // 1 = low half of an output word is staged
    logic              in_done_q;    // every input word of the frame is in
    logic [15:0]       stage_q;      // first pooled pair of an output word

    logic              m_valid_q;
    logic              m_last_q;
    logic [31:0]       m_data_q;
    logic              done_q;
    logic              err_q;

    logic [15:0]       lb_mem [LB_DEPTH];

    // -------------------------------------------------------------------------
    // Geometry decode for start
    // -------------------------------------------------------------------------
    logic [8:0] w_masked;
    logic [8:0] w_clamped;
    logic       geom_ok;

    always_comb begin
        w_masked  = width_ex & 9'h1F8;
        w_clamped = (w_masked > MAX_W) ? MAX_W : w_masked;
        geom_ok   = (w_masked >= 9'd8) && (height_ex >= 9'd2);
    end

    // -------------------------------------------------------------------------
    // Handshakes and frame position
    // -------------------------------------------------------------------------
    logic out_stall;
    logic accept;
    logic out_fire;
    logic last_col;
    logic last_row;
    logic odd_row;
    logic last_pool_row;
    logic frame_end;

    // Input is taken only when the output register is free or is draining
    // in this cycle. This keeps a stalled output word safe from overwrite.
    // in_done_q also closes the input once the frame is complete, so that an
    // even-height frame waiting on its final output handshake cannot swallow
    // the first word of the next frame.
    assign out_stall     = m_valid_q && !M_AXIS_TREADY;
    assign S_AXIS_TREADY = (state_q == S_RUN) && !in_done_q && !out_stall;
    assign accept        = S_AXIS_TVALID && S_AXIS_TREADY;
    assign out_fire      = m_valid_q && M_AXIS_TREADY;

    assign last_col      = (col_q == col_last_q);
    assign last_row      = (row_q == height_q - 9'd1);
    assign odd_row       = row_q[0];
    assign last_pool_row = (row_q[8:1] == height_q[8:1] - 8'd1);

    // For an odd height, the trailing row produces no output. The frame
    // therefore ends when that row's last word is accepted. For an even
    // height, it ends when the TLAST-marked output word leaves.
    assign frame_end = height_q[0] ? (accept && last_row && last_col)
                                   : (out_fire && m_last_q);

    // -------------------------------------------------------------------------
    // Pixel data path
    // -------------------------------------------------------------------------
    logic [7:0]  h0;
    logic [7:0]  h1;
    logic [15:0] lb_rd;
    logic [7:0]  v0;
    logic [7:0]  v1;

    always_comb begin
        h0    = smax8(S_AXIS_TDATA[7:0],   S_AXIS_TDATA[15:8]);
        h1    = smax8(S_AXIS_TDATA[23:16], S_AXIS_TDATA[31:24]);
        lb_rd = lb_mem[col_q];
        v0    = smax8(h0, lb_rd[7:0]);
        v1    = smax8(h1, lb_rd[15:8]);
    end

    // NOTE: the line buffer has no reset. Its entries are always written on an
    // even row before any odd row reads them, so clearing it would add reset
    // fan-out for no functional gain and would block RAM inference.
    always_ff @(posedge clk) begin
        if (accept && !odd_row) begin
            lb_mem[col_q] <= {h1, h0};
        end
    end

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal driven here gets a default before the case
    // statement, so no path through the block can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = geom_ok ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (frame_end) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Counters, status and output register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then samples pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q      <= '0;
            col_last_q <= '0;
            row_q      <= '0;
            height_q   <= '0;
            half_q     <= 1'b0;
            in_done_q  <= 1'b0;
            stage_q    <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            m_data_q   <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= (state_q == S_DONE);

            if (state_q == S_IDLE && start) begin
                col_q      <= '0;
                row_q      <= '0;
                half_q     <= 1'b0;
                in_done_q  <= 1'b0;
                err_q      <= 1'b0;
                height_q   <= height_ex;
                col_last_q <= LB_AW'((w_clamped >> 2) - 9'd1);
            end

            if (accept) begin
                if (last_col) begin
                    col_q <= '0;
                    row_q <= row_q + 9'd1;
                end else begin
                    col_q <= col_q + 1'b1;
                end

                if (last_col && last_row) begin
                    in_done_q <= 1'b1;
                end

                // The counters alone define the frame. Upstream TLAST is
                // only audited against them.
                if (S_AXIS_TLAST != (last_row && last_col)) begin
                    err_q <= 1'b1;
                end

                if (odd_row) begin
                    half_q <= !half_q;
                    if (!half_q) begin
                        stage_q <= {v1, v0};
                    end
                end
            end

            // A load takes priority over a drain. When both happen in the
            // same cycle, the new word replaces the one just accepted
            // downstream, which sustains one word per cycle.
            if (accept && odd_row && half_q) begin
                m_valid_q <= 1'b1;
                m_data_q  <= {v1, v0, stage_q};
                m_last_q  <= last_pool_row && last_col;
            end else if (out_fire) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    assign M_AXIS_TVALID = m_valid_q;
    assign M_AXIS_TDATA  = m_data_q;
    assign M_AXIS_TLAST  = m_last_q;
    assign M_AXIS_TKEEP  = 4'hF;
    assign pool_done     = done_q;
    assign tlast_err     = err_q;

endmodule

// File: tb/tb_maxpool_stream.sv
// -----------------------------------------------------------------------------
// tb_maxpool_stream
//
// Drives random and directed frames into maxpool_stream and compares the
// pooled stream against a reference model. The model builds each output word
// directly from the 2x2 window maxima of the pixel array.
// -----------------------------------------------------------------------------
module tb_maxpool_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [8:0]  width_ex;
    logic [8:0]  height_ex;
    logic        pool_done;
    logic        tlast_err;
    logic        s_tready;
    logic [31:0] s_tdata;
    logic        s_tlast;
    logic        s_tvalid;
    logic        m_tready;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tlast;
    logic        m_tvalid;

    always #5 clk = ~clk;

    maxpool_stream #(
        .C_S00_AXIS_TDATA_WIDTH(32),
        .LB_DEPTH              (64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .width_ex     (width_ex),
        .height_ex    (height_ex),
        .pool_done    (pool_done),
        .tlast_err    (tlast_err),
        .S_AXIS_TREADY(s_tready),
        .S_AXIS_TDATA (s_tdata),
        .S_AXIS_TLAST (s_tlast),
        .S_AXIS_TVALID(s_tvalid),
        .M_AXIS_TREADY(m_tready),
        .M_AXIS_TDATA (m_tdata),
        .M_AXIS_TKEEP (m_tkeep),
        .M_AXIS_TLAST (m_tlast),
        .M_AXIS_TVALID(m_tvalid)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [7:0] pix [8][256];

    typedef struct {
        logic [31:0] data;
        logic        last;
    } out_t;

    out_t        exp_q[$];
    logic [31:0] last_out;

    // mode 0: pixel = raster index
    // mode 1: random pixels
    // mode 2: every pixel 0x80 except one 0xFF per 2x2 window
    task automatic build_frame(input int w, input int h, input int mode);
        int dy;
        int dx;
        for (int r = 0; r < h; r++) begin
            for (int x = 0; x < w; x++) begin
                case (mode)
                    0:       pix[r][x] = 8'(r * w + x);
                    1:       pix[r][x] = 8'($urandom);
                    default: pix[r][x] = 8'h80;
                endcase
            end
        end
        if (mode == 2) begin
            for (int r = 0; r + 1 < h; r += 2) begin
                for (int x = 0; x < w; x += 2) begin
                    dy = int'($urandom_range(0, 1));
                    dx = int'($urandom_range(0, 1));
                    pix[r + dy][x + dx] = 8'hFF;
                end
            end
        end
    endtask

    task automatic build_expected(input int w, input int h);
        int          n_pool_rows;
        int          words_per_row;
        int          best;
        int          val;
        logic [31:0] word;
        logic signed [7:0] sp;
        out_t        item;
        n_pool_rows   = h / 2;
        words_per_row = w / 8;
        exp_q.delete();
        for (int pr = 0; pr < n_pool_rows; pr++) begin
            for (int k = 0; k < words_per_row; k++) begin
                word = '0;
                for (int b = 0; b < 4; b++) begin
                    best = -1000;
                    for (int dy = 0; dy < 2; dy++) begin
                        for (int dx = 0; dx < 2; dx++) begin
                            sp  = pix[2 * pr + dy][2 * (4 * k + b) + dx];
                            val = int'(sp);
                            if (val > best) best = val;
                        end
                    end
                    word[8 * b +: 8] = 8'(best);
                end
                item.data = word;
                item.last = (pr == n_pool_rows - 1) && (k == words_per_row - 1);
                exp_q.push_back(item);
            end
        end
    endtask

    // Runs one valid frame. tlast_pos < 0 places TLAST on the final word.
    task automatic run_frame(input string name, input int w_ex, input int h,
                             input int mode, input int rdy_pct, input int vld_pct,
                             input int tlast_pos);
        int          w;
        int          wr;
        int          n_in;
        int          idx;
        int          cyc;
        int          last_evt;
        int          done_cyc;
        int          tl_pos;
        bit          done_seen;
        bit          held;
        logic [31:0] held_data;
        logic        held_last;
        out_t        item;

        w = w_ex & ~7;
        if (w > 256) w = 256;
        wr     = w / 4;
        n_in   = wr * h;
        tl_pos = (tlast_pos < 0) ? n_in - 1 : tlast_pos;
        build_frame(w, h, mode);
        build_expected(w, h);

        @(negedge clk);
        width_ex  = 9'(w_ex);
        height_ex = 9'(h);
        start     = 1'b1;
        s_tvalid  = 1'b0;
        m_tready  = 1'b0;
        @(negedge clk);
        start = 1'b0;

        idx       = 0;
        cyc       = 0;
        last_evt  = -100;
        done_cyc  = -1;
        done_seen = 1'b0;
        held      = 1'b0;
        held_data = '0;
        held_last = 1'b0;

        while (!done_seen && cyc < 20000) begin
            if (cyc > 0) @(negedge clk);
            s_tvalid = (idx < n_in) && ($urandom_range(0, 99) < vld_pct);
            s_tdata  = '0;
            if (idx < n_in) begin
                for (int b = 0; b < 4; b++) begin
                    s_tdata[8 * b +: 8] = pix[idx / wr][4 * (idx % wr) + b];
                end
            end
            s_tlast  = s_tvalid && (idx == tl_pos);
            m_tready = ($urandom_range(0, 99) < rdy_pct);
            #1;

            if (cyc == 0) check({name, "/err_clr"}, 32'(tlast_err), 32'd0);

            if (held) begin
                check({name, "/hold_valid"}, 32'(m_tvalid), 32'd1);
                check({name, "/hold_data"}, m_tdata, held_data);
                check({name, "/hold_last"}, 32'(m_tlast), 32'(held_last));
            end

            if (idx < n_in) begin
                check({name, "/tready"}, 32'(s_tready), 32'(!(m_tvalid && !m_tready)));
            end

            if (pool_done) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
            end

            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    check({name, "/extra_out"}, 32'd1, 32'd0);
                end else begin
                    item = exp_q.pop_front();
                    check({name, "/data"}, m_tdata, item.data);
                    check({name, "/tlast"}, 32'(m_tlast), 32'(item.last));
                    last_out = m_tdata;
                    if (item.last && (h % 2 == 0)) last_evt = cyc;
                end
            end

            held      = m_tvalid && !m_tready;
            held_data = m_tdata;
            held_last = m_tlast;

            if (s_tvalid && s_tready) begin
                if (idx == n_in - 1 && (h % 2 == 1)) last_evt = cyc;
                idx++;
            end
            cyc++;
        end

        if (!done_seen) begin
            check({name, "/timeout"}, 32'd0, 32'd1);
        end else begin
            check({name, "/done_lat"}, 32'(done_cyc - last_evt), 32'd2);
        end
        check({name, "/in_count"}, 32'(idx), 32'(n_in));
        check({name, "/out_left"}, 32'(exp_q.size()), 32'd0);
        check({name, "/tlast_err"}, 32'(tlast_err), 32'(tl_pos != n_in - 1));

        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        #1;
        check({name, "/done_pulse"}, 32'(pool_done), 32'd0);
        check({name, "/idle_tready"}, 32'(s_tready), 32'd0);
    endtask

    initial begin
        int acc;

        rst       = 1'b1;
        start     = 1'b0;
        width_ex  = '0;
        height_ex = '0;
        s_tdata   = '0;
        s_tlast   = 1'b0;
        s_tvalid  = 1'b0;
        m_tready  = 1'b0;
        last_out  = '0;

        repeat (3) @(negedge clk);
        #1;
        check("rst/s_tready", 32'(s_tready), 32'd0);
        check("rst/m_tvalid", 32'(m_tvalid), 32'd0);
        check("rst/m_tdata", m_tdata, 32'd0);
        check("rst/m_tlast", 32'(m_tlast), 32'd0);
        check("rst/pool_done", 32'(pool_done), 32'd0);
        check("rst/tlast_err", 32'(tlast_err), 32'd0);
        check("rst/m_tkeep", 32'(m_tkeep), 32'hF);
        rst = 1'b0;

        // Raster index: rows 0..7 and 8..15 pool to 09, 0B, 0D, 0F.
        run_frame("index", 8, 2, 0, 100, 100, -1);
        check("index/word", last_out, 32'h0F0D0B09);

        // A single 0xFF (-1) per window must beat 0x80 (-128).
        run_frame("signed", 8, 2, 2, 100, 100, -1);
        check("signed/word", last_out, 32'hFFFFFFFF);

        run_frame("backpressure", 16, 4, 1, 30, 80, -1);
        run_frame("odd_height", 8, 3, 1, 100, 100, -1);
        run_frame("tlast_mismatch", 8, 2, 1, 100, 100, 1);
        run_frame("low_bits", 13, 2, 1, 60, 70, -1);
        run_frame("clamp", 300, 2, 1, 70, 90, -1);
        run_frame("mixed", 24, 5, 1, 50, 60, -1);
        run_frame("signed_big", 32, 6, 2, 40, 100, -1);

        // Invalid start: width below 8 pixels. No data is accepted.
        @(negedge clk);
        width_ex  = 9'd4;
        height_ex = 9'd4;
        start     = 1'b1;
        s_tvalid  = 1'b1;
        m_tready  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("invalid/tready1", 32'(s_tready), 32'd0);
        check("invalid/done1", 32'(pool_done), 32'd0);
        @(negedge clk);
        #1;
        check("invalid/tready2", 32'(s_tready), 32'd0);
        check("invalid/done2", 32'(pool_done), 32'd1);
        @(negedge clk);
        #1;
        check("invalid/done3", 32'(pool_done), 32'd0);
        s_tvalid = 1'b0;

        // Invalid start: height 1.
        @(negedge clk);
        width_ex  = 9'd16;
        height_ex = 9'd1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1;
        check("invalid_h/done", 32'(pool_done), 32'd1);

        // Reset mid-frame, with an output word stalled and tlast_err set.
        @(negedge clk);
        width_ex  = 9'd16;
        height_ex = 9'd4;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        acc   = 0;
        for (int k = 0; k < 100 && acc < 6; k++) begin
            if (k > 0) @(negedge clk);
            s_tvalid = 1'b1;
            s_tdata  = $urandom;
            s_tlast  = (acc == 0);
            m_tready = 1'b0;
            #1;
            if (s_tready) acc++;
        end
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        #1;
        check("midrst/pre_valid", 32'(m_tvalid), 32'd1);
        check("midrst/pre_err", 32'(tlast_err), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("midrst/m_tvalid", 32'(m_tvalid), 32'd0);
        check("midrst/m_tdata", m_tdata, 32'd0);
        check("midrst/m_tlast", 32'(m_tlast), 32'd0);
        check("midrst/s_tready", 32'(s_tready), 32'd0);
        check("midrst/pool_done", 32'(pool_done), 32'd0);
        check("midrst/tlast_err", 32'(tlast_err), 32'd0);
        rst = 1'b0;

        run_frame("post_reset", 16, 4, 1, 50, 80, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
